avalon_mm_copy_master: RTL

- Avalon-MM initiator that copies a block of 32-bit words from a source byte address to a destination byte address.
- Used to fill, copy and scrub the on-chip single-port RAM slaves in the MPSoC, either through the interconnect or directly.
- Commanded by a simple start/busy/done interface from a CPU-side control register block.
- One read outstanding at a time; each word is read, held in a 1-entry buffer, then written.

---
 rtl/avalon_mm_copy_pkg.sv | 15 +
 rtl/avalon_mm_copy_master.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/avalon_mm_copy_pkg.sv
// Shared types and constants for the Avalon-MM block copy initiator.
package avalon_mm_copy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      FINISH
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam logic [3:0]  BE_ALL         = 4'hF;

endpackage

// File: rtl/avalon_mm_copy_master.sv
// Avalon-MM initiator copying a block of 32-bit words, one read outstanding at a time,
// through a single-word holding buffer.
module avalon_mm_copy_master
   import avalon_mm_copy_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [CNT_W-1:0]  cmd_len,
   input  logic              cmd_abort,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [CNT_W-1:0]  words_done,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [3:0]        m_byteenable,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_readdatavalid,
   input  logic              m_waitrequest
);

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BYTES_PER_WORD);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [CNT_W-1:0]  len_q, len_d, cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              aborted_q, aborted_d;
   logic              gap_q, gap_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         buf_q     <= '0;
         aborted_q <= 1'b0;
         gap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         buf_q     <= buf_d;
         aborted_q <= aborted_d;
         gap_q     <= gap_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      buf_d        = buf_q;
      aborted_d    = aborted_q;
      gap_d        = gap_q;
      busy         = 1'b0;
      done         = 1'b0;
      m_read       = 1'b0;
      m_write      = 1'b0;
      m_address    = '0;
      m_byteenable = '0;

      unique case (state_q)
         IDLE: begin
            if (cmd_start) begin
               if (cmd_len != '0) begin
                  src_d     = cmd_src & ALIGN_MASK;
                  dst_d     = cmd_dst & ALIGN_MASK;
                  len_d     = cmd_len;
                  cnt_d     = '0;
                  aborted_d = 1'b0;
                  gap_d     = 1'b0;
                  state_d   = RD_REQ;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         RD_REQ: begin
            busy = 1'b1;
            // gap_q marks the mandatory idle bus cycle after each write
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               m_read       = 1'b1;
               m_address    = src_q;
               m_byteenable = BE_ALL;
               if (!m_waitrequest) state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            busy = 1'b1;
            if (m_readdatavalid) begin
               buf_d   = m_readdata;
               state_d = WR_REQ;
            end
         end
         WR_REQ: begin
            busy         = 1'b1;
            m_write      = 1'b1;
            m_address    = dst_q;
            m_byteenable = BE_ALL;
            if (!m_waitrequest) begin
               src_d = src_q + STEP;
               dst_d = dst_q + STEP;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == len_q || cmd_abort) begin
                  state_d = FINISH;
                  if (cnt_d != len_q) aborted_d = 1'b1;
               end else begin
                  gap_d   = 1'b1;
                  state_d = RD_REQ;
               end
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_writedata = buf_q;
   assign words_done  = cnt_q;
   assign aborted     = aborted_q;

endmodule
